// File: rtl/sdspi_engine.sv
// ---------------------------------------------------------------------------
// sdspi_engine
//
// SPI mode-0 bit engine for the RK8E SD card controller. It executes one
// spiOP_t command at a time, drives the card pins (SCLK/MOSI/CS) and shifts
// in MISO. Each spiTR moves one byte, MSB first.
//
// spiOP_t encoding: 0 spiNOP, 1 spiCSL, 2 spiCSH, 3 spiFAST, 4 spiSLOW,
//                   5 spiTR. Encodings 6 and 7 behave like spiNOP.
//
// Parameters:
//   SLOW_DIV  clk cycles per SCLK half-period in slow mode (>= 1)
//   FAST_DIV  clk cycles per SCLK half-period in fast mode (>= 1)
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   spiOP     command strobe (one cycle), spiNOP otherwise
//   spiTXD    byte to transmit, sampled together with spiTR
//   spiRXD    last received byte, valid from spiDONE onward
//   spiDONE   one-cycle pulse when an accepted op completes
//   spiBUSY   high while an accepted op is in progress
//   sdMISO    card data out
//   sdMOSI    card data in
//   sdCLK     SPI clock, idles low
//   sdCS      card chip select, active low
//   loopback  internal MOSI->MISO loop (only with SDSPI_LOOPBACK_EN)
//
// Build option:
//   SDSPI_LOOPBACK_EN  adds the loopback port; when loopback=1 the receive
//                      path samples the engine's own sdMOSI instead of sdMISO.
// ---------------------------------------------------------------------------
module sdspi_engine #(
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] spiOP,
    input  logic [7:0] spiTXD,
    output logic [7:0] spiRXD,
    output logic       spiDONE,
    output logic       spiBUSY,
`ifdef SDSPI_LOOPBACK_EN
    input  logic       loopback,
`endif
    input  logic       sdMISO,
    output logic       sdMOSI,
    output logic       sdCLK,
    output logic       sdCS
);

    localparam logic [2:0] OP_CSL  = 3'd1;
    localparam logic [2:0] OP_CSH  = 3'd2;
    localparam logic [2:0] OP_FAST = 3'd3;
    localparam logic [2:0] OP_SLOW = 3'd4;
    localparam logic [2:0] OP_TR   = 3'd5;

    localparam logic [15:0] SLOW_HALF = 16'(SLOW_DIV);
    localparam logic [15:0] FAST_HALF = 16'(FAST_DIV);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        TR_LO,
        TR_HI,
        TR_END,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        fast_mode;
    logic [15:0] div_len;
    logic [15:0] div_cnt;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_cnt;
    logic        rx_in;
    logic [15:0] cur_div;
    logic        div_zero;
    logic        last_bit;

    // Receive source: either the card pin or, in loopback builds, our own
    // MOSI so a byte can be echoed without a card present.
`ifdef SDSPI_LOOPBACK_EN
    assign rx_in = loopback ? sdMOSI : sdMISO;
`else
    assign rx_in = sdMISO;
`endif

    assign cur_div  = fast_mode ? FAST_HALF : SLOW_HALF;
    assign div_zero = (div_cnt == 16'd0);
    assign last_bit = (bit_cnt == 3'd7);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Ops are only looked at in IDLE, so anything issued
    // while busy is dropped. TR_END is a one-cycle settle after the last
    // falling edge so a transfer completes 16*DIV+1 cycles after accept.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (spiOP == OP_TR) begin
                    state_next = TR_LO;
                end else if (spiOP == OP_CSL || spiOP == OP_CSH ||
                             spiOP == OP_FAST || spiOP == OP_SLOW) begin
                    state_next = CMD;
                end
            end
            CMD:    state_next = DONE;
            TR_LO:  if (div_zero) state_next = TR_HI;
            TR_HI: begin
                if (div_zero) begin
                    state_next = last_bit ? TR_END : TR_LO;
                end
            end
            TR_END: state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        spiBUSY = (state != IDLE);
        spiDONE = (state == DONE);
    end

    // Pin and datapath registers. The divisor is latched at accept so a
    // speed change can never disturb a byte already in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            sdCS      <= 1'b1;
            sdCLK     <= 1'b0;
            sdMOSI    <= 1'b1;
            spiRXD    <= 8'h00;
            fast_mode <= 1'b0;
            div_len   <= SLOW_HALF;
            div_cnt   <= 16'd0;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    case (spiOP)
                        OP_CSL:  sdCS      <= 1'b0;
                        OP_CSH:  sdCS      <= 1'b1;
                        OP_FAST: fast_mode <= 1'b1;
                        OP_SLOW: fast_mode <= 1'b0;
                        OP_TR: begin
                            shift_reg <= spiTXD;
                            sdMOSI    <= spiTXD[7];
                            div_len   <= cur_div;
                            div_cnt   <= cur_div - 16'd1;
                            bit_cnt   <= 3'd0;
                        end
                        default: ;
                    endcase
                end
                TR_LO: begin
                    if (div_zero) begin
                        // Rising SCLK: sample into the LSB; the next bit to
                        // send moves up into the MSB at the same time.
                        sdCLK     <= 1'b1;
                        shift_reg <= {shift_reg[6:0], rx_in};
                        div_cnt   <= div_len - 16'd1;
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                TR_HI: begin
                    if (div_zero) begin
                        sdCLK   <= 1'b0;
                        div_cnt <= div_len - 16'd1;
                        if (last_bit) begin
                            sdMOSI  <= 1'b1;
                            bit_cnt <= 3'd0;
                        end else begin
                            sdMOSI  <= shift_reg[7];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt - 16'd1;
                    end
                end
                TR_END: begin
                    spiRXD <= shift_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sdspi_engine.sv
// ---------------------------------------------------------------------------
// tb_sdspi_engine
//
// Directed bench for sdspi_engine. Stimulus pushes the expected completion
// (latency, received byte, transmitted byte, pulse count) into a scoreboard
// queue; a monitor pops an entry on every spiDONE pulse and compares. A small
// card model shifts a preset byte out on MISO, MSB first.
// ---------------------------------------------------------------------------
module tb_sdspi_engine;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_CSL  = 3'd1;
    localparam logic [2:0] OP_CSH  = 3'd2;
    localparam logic [2:0] OP_FAST = 3'd3;
    localparam logic [2:0] OP_TR   = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] spiOP;
    logic [7:0] spiTXD;
    logic [7:0] spiRXD;
    logic       spiDONE;
    logic       spiBUSY;
    logic       sdMISO;
    logic       sdMOSI;
    logic       sdCLK;
    logic       sdCS;
`ifdef SDSPI_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    sdspi_engine #(.SLOW_DIV(63), .FAST_DIV(1)) dut (
        .clk     (clk),
        .reset   (reset),
        .spiOP   (spiOP),
        .spiTXD  (spiTXD),
        .spiRXD  (spiRXD),
        .spiDONE (spiDONE),
        .spiBUSY (spiBUSY),
`ifdef SDSPI_LOOPBACK_EN
        .loopback(loopback),
`endif
        .sdMISO  (sdMISO),
        .sdMOSI  (sdMOSI),
        .sdCLK   (sdCLK),
        .sdCS    (sdCS)
    );

    always #5 clk = ~clk;

    // Cycle counter, advanced on every rising clk edge
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string      name;
        int         accept_cyc;
        int         lat;
        logic [7:0] rxd;
        bit         chk_tr;
        logic [7:0] mosi;
        int         base;
    } exp_t;

    exp_t sb[$];

    // Card model: byte presented MSB first, one bit per SCLK rising edge
    // counted from slave_base; MOSI captured on every SCLK rising edge.
    logic [7:0] slave_byte = 8'hFF;
    int         slave_base = 0;
    int         rise_cnt   = 0;
    logic [7:0] mosi_cap   = 8'h00;
    int         miso_idx;

    always @(posedge sdCLK) begin
        rise_cnt <= rise_cnt + 1;
        mosi_cap <= {mosi_cap[6:0], sdMOSI};
    end

    assign miso_idx = rise_cnt - slave_base;

    always_comb begin
        sdMISO = 1'b1;
        if (miso_idx >= 0 && miso_idx < 8) begin
            sdMISO = slave_byte[3'(7 - miso_idx)];
        end
    end

    // Compare helper shared by monitor and stimulus
    task automatic checkOutput(input string name, input int got, input int expv);
        compared = compared + 1;
        if (got != expv) begin
            mismatched = mismatched + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
        end
    endtask

    // Monitor: every spiDONE pulse must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (spiDONE) begin
            if (sb.size() == 0) begin
                compared   = compared + 1;
                mismatched = mismatched + 1;
                $display("[TB] FAIL unexpected_done: got spiDONE at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput({e.name, "_latency"}, cyc - e.accept_cyc, e.lat);
                if (e.chk_tr) begin
                    checkOutput({e.name, "_rxd"}, int'(spiRXD), int'(e.rxd));
                    checkOutput({e.name, "_mosi"}, int'(mosi_cap), int'(e.mosi));
                    checkOutput({e.name, "_pulses"}, rise_cnt - e.base, 8);
                end
            end
        end
    end

    // Drive one op strobe for a single cycle; returns at the negedge just
    // after the accept edge, with the expected completion queued.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] txd,
                                 input bit expect_done, input int lat,
                                 input logic [7:0] rxd, input string name);
        exp_t e;
        @(negedge clk);
        if (op == OP_TR) slave_base = rise_cnt;
        spiOP  = op;
        spiTXD = txd;
        @(negedge clk);
        spiOP  = OP_NOP;
        if (expect_done) begin
            e.name       = name;
            e.accept_cyc = cyc;
            e.lat        = lat;
            e.rxd        = rxd;
            e.chk_tr     = (op == OP_TR);
            e.mosi       = txd;
            e.base       = slave_base;
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle(input int max_cycles, input string name);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!spiBUSY && sb.size() == 0) return;
        end
        compared   = compared + 1;
        mismatched = mismatched + 1;
        $display("[TB] FAIL %s_timeout: got busy=%0d pending=%0d expected idle", name, spiBUSY, sb.size());
    endtask

    task automatic waitSclk(input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sdCLK == lvl) begin
                at = cyc;
                return;
            end
        end
        compared   = compared + 1;
        mismatched = mismatched + 1;
        $display("[TB] FAIL sclk_wait: got no SCLK=%0d expected edge", lvl);
    endtask

    int t1, t2, t3;

    initial begin
        reset  = 1'b1;
        spiOP  = OP_NOP;
        spiTXD = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_cs",   sdCS,    1);
        checkOutput("reset_sclk", sdCLK,   0);
        checkOutput("reset_mosi", sdMOSI,  1);
        checkOutput("reset_rxd",  spiRXD,  0);
        checkOutput("reset_done", spiDONE, 0);
        checkOutput("reset_busy", spiBUSY, 0);
        reset = 1'b0;

        // Chip select control and ops that must never be accepted
        applyStimulus(OP_CSL, 8'h00, 1'b1, 1, 8'h00, "csl");
        checkOutput("csl_cs",   sdCS,    0);
        checkOutput("csl_busy", spiBUSY, 1);
        waitIdle(20, "csl");
        applyStimulus(OP_CSH, 8'h00, 1'b1, 1, 8'h00, "csh");
        checkOutput("csh_cs", sdCS, 1);
        waitIdle(20, "csh");
        applyStimulus(OP_NOP, 8'h00, 1'b0, 0, 8'h00, "nop");
        checkOutput("nop_busy", spiBUSY, 0);
        applyStimulus(3'd6, 8'h00, 1'b0, 0, 8'h00, "ill6");
        checkOutput("ill6_busy", spiBUSY, 0);
        applyStimulus(3'd7, 8'h00, 1'b0, 0, 8'h00, "ill7");
        checkOutput("ill7_busy", spiBUSY, 0);
        repeat (5) @(negedge clk);

        // Fast byte
        applyStimulus(OP_FAST, 8'h00, 1'b1, 1, 8'h00, "fast");
        waitIdle(20, "fast");
        slave_byte = 8'hA5;
        applyStimulus(OP_TR, 8'h40, 1'b1, 17, 8'hA5, "tr_fast");
        checkOutput("tr_fast_busy", spiBUSY, 1);
        waitIdle(100, "tr_fast");

        // Slow timing after reset (speed returns to slow)
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        slave_byte = 8'hFF;
        applyStimulus(OP_TR, 8'hFF, 1'b1, 1009, 8'hFF, "tr_slow");
        waitSclk(1'b1, t1);
        waitSclk(1'b0, t2);
        waitSclk(1'b1, t3);
        checkOutput("slow_high", t2 - t1, 63);
        checkOutput("slow_low",  t3 - t2, 63);
        waitIdle(1200, "tr_slow");

        // Ops dropped while busy
        applyStimulus(OP_FAST, 8'h00, 1'b1, 1, 8'h00, "fast2");
        waitIdle(20, "fast2");
        applyStimulus(OP_CSL, 8'h00, 1'b1, 1, 8'h00, "csl2");
        waitIdle(20, "csl2");
        slave_byte = 8'h5A;
        applyStimulus(OP_TR, 8'h81, 1'b1, 17, 8'h5A, "tr_drop");
        repeat (3) @(negedge clk);
        applyStimulus(OP_CSH, 8'h00, 1'b0, 0, 8'h00, "csh_drop");
        checkOutput("drop_cs", sdCS, 0);
        waitIdle(100, "tr_drop");

        // Reset in the middle of a byte: no completion may appear
        slave_byte = 8'h00;
        applyStimulus(OP_TR, 8'h00, 1'b0, 0, 8'h00, "tr_abort");
        for (int i = 0; i < 50; i++) begin
            if (rise_cnt - slave_base >= 3) break;
            @(negedge clk);
        end
        checkOutput("abort_pulses", rise_cnt - slave_base, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_sclk", sdCLK,   0);
        checkOutput("abort_cs",   sdCS,    1);
        checkOutput("abort_busy", spiBUSY, 0);
        checkOutput("abort_mosi", sdMOSI,  1);
        checkOutput("abort_rxd",  spiRXD,  0);
        repeat (20) @(negedge clk);

        // Normal transfer after the abort
        applyStimulus(OP_FAST, 8'h00, 1'b1, 1, 8'h00, "fast3");
        waitIdle(20, "fast3");
        slave_byte = 8'h96;
        applyStimulus(OP_TR, 8'hC3, 1'b1, 17, 8'h96, "tr_after");
        waitIdle(100, "tr_after");

`ifdef SDSPI_LOOPBACK_EN
        // Loopback: card drives zeros, the byte must come back from MOSI
        loopback   = 1'b1;
        slave_byte = 8'h00;
        applyStimulus(OP_TR, 8'h3C, 1'b1, 17, 8'h3C, "tr_loop");
        waitIdle(100, "tr_loop");
        loopback = 1'b0;
`endif

        repeat (5) @(negedge clk);
        checkOutput("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected end of run");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
